// File: rtl/apb_mem_slave_pkg.sv
// Shared types and default widths for the APB memory completer slice.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
interface apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_mem_slave_wait_ctr.sv
// Loadable down-counter for APB wait states; done is high while the count is zero.
module apb_wait_ctr
    import apb_pkg::*;
(
    input  logic              pclk,
    input  logic              prst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              done
);

    logic [WAIT_W-1:0] count_q;

    always_ff @(posedge pclk) begin
        if (!prst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && !done) begin
            count_q <= count_q - WAIT_W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer with a word-addressed register memory, fixed wait states
// and pslverr on out-of-range addresses. All outputs are registered.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1
) (
    input logic  pclk,
    input logic  prst,
    apb_if.slave bus
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
    // One less than the wait count: the last wait cycle is the edge that raises pready.
    localparam logic [WAIT_W-1:0] WAIT_LD = ZERO_WAIT ? '0 : WAIT_W'(WAIT_CYCLES - 1);

    apb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup_req;
    logic              capture;
    logic              waiting;
    logic              respond;
    logic              ctr_done;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_wr;
    logic              rsp_ok;
    logic [DATA_W-1:0] rsp_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_EXT;
    endfunction

    assign setup_req = bus.psel && !bus.penable;
    assign capture   = setup_req && ((state_q == IDLE) || pready_q);
    assign waiting   = (state_q != IDLE) && !pready_q && bus.psel && bus.penable;
    assign respond   = (capture && ZERO_WAIT) || (waiting && ctr_done);

    apb_wait_ctr u_wait_ctr (
        .pclk     (pclk),
        .prst     (prst),
        .load     (capture),
        .load_val (WAIT_LD),
        .dec      (waiting),
        .done     (ctr_done)
    );

    // Zero-wait responses are built straight from the setup-phase inputs.
    always_comb begin
        rsp_addr = capture ? bus.paddr : addr_q;
        rsp_wr   = capture ? bus.pwrite : wr_q;
        rsp_ok   = in_range(rsp_addr);
        rsp_data = '0;
        if (!rsp_wr && rsp_ok) begin
            rsp_data = mem[rsp_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge pclk) begin
        if (!prst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;

            if (pready_q && bus.psel && bus.penable && wr_q && in_range(addr_q)) begin
                mem[addr_q[IDX_W-1:0]] <= wdata_q;
            end

            if (capture) begin
                addr_q  <= bus.paddr;
                wr_q    <= bus.pwrite;
                wdata_q <= bus.pwdata;
                if (ZERO_WAIT) begin
                    state_q <= ACCESS;
                end else begin
                    state_q <= SETUP;
                end
            end else if (waiting) begin
                state_q <= ACCESS;
            end else begin
                state_q <= IDLE;
            end

            if (respond) begin
                pready_q  <= 1'b1;
                pslverr_q <= !rsp_ok;
                prdata_q  <= rsp_data;
            end
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;

endmodule
